// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED toggle scheduler: FSM state encoding and
// default parameter values.
package led_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int DEFAULT_SERVICE_CYCLES = 4;
  localparam int DEFAULT_DROP_W         = 8;

endpackage

// File: rtl/led_scheduler_rr_picker.sv
// Combinational round-robin picker: returns the first pending requester after
// last_grant (wrapping) as a one-hot vector.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     pick,
  output logic             valid
);

  int idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last_grant) + off) % N;
      if (!valid && pending[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_scheduler.sv
// Round-robin LED toggle scheduler: latches toggle requests, grants one
// requester at a time, then stays busy for SERVICE_CYCLES before the next grant.
module led_scheduler
  import led_sched_pkg::*;
#(
  parameter int N              = 3,
  parameter int SERVICE_CYCLES = DEFAULT_SERVICE_CYCLES,
  parameter int DROP_W         = DEFAULT_DROP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  output logic [N-1:0]      led,
  output logic [N-1:0]      grant,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(SERVICE_CYCLES + 1);
  localparam int SUM_W = DROP_W + $clog2(N + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(SERVICE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N - 1);
  localparam logic [SUM_W-1:0] DROP_MAX   = (SUM_W'(1) << DROP_W) - SUM_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [N-1:0]      pending;
  logic [N-1:0]      pick;
  logic              valid;
  logic [N-1:0]      grant_now;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic [SUM_W-1:0]  drop_sum;

  rr_picker #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_grant),
    .pick       (pick),
    .valid      (valid)
  );

  // A grant can only be issued from IDLE; it is the bit cleared from pending.
  assign grant_now = (state == IDLE && valid) ? pick : '0;
  assign busy      = (state == SERVE);

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // A request landing on an already-pending, ungranted bit is lost.
  always_comb begin
    drop_sum = SUM_W'(drop_count);
    for (int i = 0; i < N; i++) begin
      if (req[i] && pending[i] && !grant_now[i]) drop_sum = drop_sum + SUM_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      drop_count <= '0;
    end else begin
      pending    <= (pending & ~grant_now) | req;
      drop_count <= (drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      grant      <= '0;
      led        <= '0;
      last_grant <= LAST_RESET;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (valid) begin
            grant      <= pick;
            led        <= led ^ pick;
            last_grant <= pick_idx;
            counter    <= CNT_LOAD;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (counter == '0) state <= IDLE;
          else               counter <= counter - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scheduler.sv
// Directed self-checking bench for led_scheduler (N=3, SERVICE_CYCLES=4) plus a
// DROP_W=2 instance for drop-counter saturation.
module tb_led_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] req2 = '0;
  logic [2:0] led, grant, led2, grant2;
  logic       busy, busy2;
  logic [7:0] drop_count;
  logic [1:0] drop_count2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  led_scheduler #(.N(3), .SERVICE_CYCLES(4), .DROP_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .led        (led),
    .grant      (grant),
    .busy       (busy),
    .drop_count (drop_count)
  );

  led_scheduler #(.N(3), .SERVICE_CYCLES(4), .DROP_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req2),
    .led        (led2),
    .grant      (grant2),
    .busy       (busy2),
    .drop_count (drop_count2)
  );

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next rising edge is edge 1.
  task automatic do_reset();
    req   = '0;
    req2  = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req   = '0;
    req2  = '0;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({led, grant, busy, drop_count} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got led=%b grant=%b busy=%b drop=%0d expected all zero",
               led, grant, busy, drop_count);
    end
    tests_run++;
    if (drop_count2 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_drop_sat: got %0d expected 0", drop_count2);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [2:0] exp_g;
    logic       exp_b;
    do_reset();
    step();
    req = 3'b010;
    step();
    req = 3'b000;
    tests_run++;
    if (grant !== 3'b000 || led !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_latency: got grant=%b led=%b expected 000/000", grant, led);
    end
    for (int e = 3; e <= 8; e++) begin
      step();
      exp_g = (e == 3) ? 3'b010 : 3'b000;
      exp_b = (e >= 3 && e <= 6);
      tests_run++;
      if (grant !== exp_g || busy !== exp_b || led !== 3'b010) begin
        tests_failed++;
        $display("FAIL single_cycle%0d: got grant=%b busy=%b led=%b expected %b/%b/010",
                 e, grant, busy, led, exp_g, exp_b);
      end
    end
  endtask

  task automatic test_all_three();
    logic [2:0] exp_g;
    do_reset();
    step();
    req = 3'b111;
    step();
    req = 3'b000;
    for (int e = 3; e <= 14; e++) begin
      step();
      exp_g = (e == 3) ? 3'b001 : (e == 8) ? 3'b010 : (e == 13) ? 3'b100 : 3'b000;
      tests_run++;
      if (grant !== exp_g) begin
        tests_failed++;
        $display("FAIL all_three_grant_cycle%0d: got %b expected %b", e, grant, exp_g);
      end
    end
    tests_run++;
    if (led !== 3'b111 || drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL all_three_final: got led=%b drop=%0d expected 111/0", led, drop_count);
    end
  endtask

  // Held 011: grant every 5 cycles from edge 2; each period adds 1 drop on the
  // grant edge plus 2 per SERVE edge (4 edges) = 9.
  task automatic test_held();
    logic [2:0] exp_g;
    int         k;
    do_reset();
    req = 3'b011;
    for (int e = 1; e <= 17; e++) begin
      step();
      k     = (e - 2) / 5;
      exp_g = (e >= 2 && (e - 2) % 5 == 0) ? ((k % 2 == 0) ? 3'b001 : 3'b010) : 3'b000;
      tests_run++;
      if (grant !== exp_g) begin
        tests_failed++;
        $display("FAIL held_grant_cycle%0d: got %b expected %b", e, grant, exp_g);
      end
      if (exp_g != 3'b000) begin
        tests_run++;
        if (drop_count !== 8'(1 + 9 * k)) begin
          tests_failed++;
          $display("FAIL held_drops_cycle%0d: got %0d expected %0d", e, drop_count, 1 + 9 * k);
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_double_pulse();
    int g2 = 0;
    do_reset();
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    req = 3'b100;
    step();
    req = 3'b000;
    step();
    req = 3'b100;
    step();
    req = 3'b000;
    for (int e = 6; e <= 14; e++) begin
      step();
      if (grant[2]) g2++;
      if (e == 7) begin
        tests_run++;
        if (grant !== 3'b100) begin
          tests_failed++;
          $display("FAIL double_grant_cycle7: got %b expected 100", grant);
        end
      end
    end
    tests_run++;
    if (g2 != 1 || drop_count !== 8'd1 || led !== 3'b101) begin
      tests_failed++;
      $display("FAIL double_result: got grants2=%0d drop=%0d led=%b expected 1/1/101",
               g2, drop_count, led);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_d;
    do_reset();
    req2 = 3'b001;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 4 || e == 5 || e == 6 || e == 8) begin
        exp_d = (e == 4) ? 2'd2 : 2'd3;
        tests_run++;
        if (drop_count2 !== exp_d) begin
          tests_failed++;
          $display("FAIL saturate_cycle%0d: got %0d expected %0d", e, drop_count2, exp_d);
        end
      end
    end
    req2 = 3'b000;
  endtask

  task automatic test_reset_mid_serve();
    do_reset();
    req = 3'b101;
    step();
    req = 3'b001;
    step();
    req = 3'b000;
    tests_run++;
    if (grant !== 3'b001 || busy !== 1'b1 || led !== 3'b001 || drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL midreset_pre: got grant=%b busy=%b led=%b drop=%0d expected 001/1/001/0",
               grant, busy, led, drop_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({led, grant, busy, drop_count} !== 15'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got led=%b grant=%b busy=%b drop=%0d expected all zero",
               led, grant, busy, drop_count);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      tests_run++;
      if (grant !== 3'b000 || busy !== 1'b0 || led !== 3'b000) begin
        tests_failed++;
        $display("FAIL midreset_after_cycle%0d: got grant=%b busy=%b led=%b expected 000/0/000",
                 e, grant, busy, led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_held();
    test_double_pulse();
    test_saturate();
    test_reset_mid_serve();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 Parameter N, default 3: number of requesters and LED bits.
REQ-002 Parameter SERVICE_CYCLES, default 4: busy cycles after each grant; legal range ≥1.
REQ-003 Parameter DROP_W, default 8: width of the drop counter.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-006 Port req, input, N: per-requester toggle request, sampled every edge; typically a one-cycle pulse from a signal generator.
REQ-007 Port led, output, N: registered LED state; bit i toggles only when requester i is granted.
REQ-008 Port grant, output, N: registered one-hot grant, high one cycle per service.
REQ-009 Port busy, output, 1: high while in SERVE.
REQ-010 Port drop_count, output, DROP_W: saturating count of lost requests.

Function
REQ-011 Internal pending[N-1:0] SHALL update each edge as pending_next = (pending & ~grant_now) | req.
REQ-012 The FSM SHALL have two states, IDLE and SERVE.
REQ-013 In IDLE with pending nonzero, the block SHALL select one requester round-robin, assert grant for that bit next cycle, toggle its led bit on the same edge, and enter SERVE.
REQ-014 Grant selection SHALL use registered pending only; req high at edge k yields grant high in the cycle after edge k+1 (latency 1 edge).
REQ-015 Round-robin: search starts at last_grant+1 mod N, wrapping; last_grant updates on every grant.
REQ-016 On entry to SERVE the counter SHALL load SERVICE_CYCLES-1 and decrement each edge; when counter is 0, the next edge returns to IDLE.
REQ-017 Minimum spacing between grants SHALL be SERVICE_CYCLES+1 cycles; a grant is never issued from SERVE.
REQ-018 grant SHALL be all-zero outside the single grant cycle and never have more than one bit set.
REQ-019 Drop: req[i] high while pending[i]=1 and i not granted that edge SHALL count as one drop; pending[i] stays 1.
REQ-020 req[i] on the same edge that i is granted SHALL re-set pending[i] and SHALL NOT count as a drop.
REQ-021 drop_count SHALL increase by the number of drops in that cycle and saturate at 2^DROP_W-1 without wrapping.
REQ-022 IDLE with pending zero SHALL hold all outputs; busy = (state == SERVE).

Reset
REQ-023 rst_n low SHALL immediately force led=0, grant=0, busy=0, drop_count=0, pending=0, state=IDLE, counter=0, last_grant=N-1 (requester 0 has first priority).
REQ-024 Reset mid-SERVE SHALL abandon the service; outstanding requests are discarded, not counted as drops.
REQ-025 The first grant after rst_n deassertion SHALL come no earlier than the second rising edge.

Structure
REQ-026 A shared package led_sched_pkg SHALL hold the state encoding (IDLE, SERVE) and the default SERVICE_CYCLES/DROP_W constants.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs pending and last_grant; outputs one-hot pick and valid).

Verification (N=3, SERVICE_CYCLES=4 unless noted)
REQ-028 req=3'b010 pulsed at edge 2 -> grant=3'b010 in cycle 3 only, led 000->010, busy high cycles 3-6, IDLE at cycle 7.
REQ-029 req=3'b111 one pulse after reset -> grants 001, 010, 100 spaced 5 cycles apart, final led=3'b111, drop_count=0.
REQ-030 req=3'b011 held high continuously -> grants alternate 001, 010, 001, ...; drop_count increments on held bits not granted.
REQ-031 req[2] pulsed twice during one SERVE before its grant -> one grant to requester 2, drop_count=1.
REQ-032 DROP_W=2, five drops -> drop_count saturates at 3.
REQ-033 rst_n low during SERVE with pending=3'b101 -> all outputs 0 asynchronously, no grant after release until new req.
